// File: rtl/irda_player_scheduler_if.sv
// Register-window bus shared by the player scheduler and its host.
// Read data is a separate port because the window drives it to high impedance when it is not addressed.
interface irda_player_scheduler_if;
    logic        wReadEnable;
    logic        wWriteEnable;
    logic [3:0]  wByteEnable;
    logic [31:0] wAddress;
    logic [31:0] wWriteData;

    modport master (
        output wReadEnable,
        output wWriteEnable,
        output wByteEnable,
        output wAddress,
        output wWriteData
    );

    modport slave (
        input wReadEnable,
        input wWriteEnable,
        input wByteEnable,
        input wAddress,
        input wWriteData
    );
endinterface

// File: rtl/irda_player_scheduler.sv
// Routes IrDA remote frames to four player slots by customer code, suppresses key repeats,
// and serves slots to the host by direct select or by a round-robin NEXT register.
module irda_player_scheduler #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0500,
    parameter int unsigned HOLDOFF   = 2_500_000,
    parameter logic [15:0] ID0       = 16'h7F80,
    parameter logic [15:0] ID1       = 16'h2C2C,
    parameter logic [15:0] ID2       = 16'h2487,
    parameter logic [15:0] ID3       = 16'h46B9
) (
    input  logic                           iCLK,
    input  logic                           Reset,
    input  logic                           iFrameValid,
    input  logic [31:0]                    iFrame,
    irda_player_scheduler_if.slave         bus,
    output logic [31:0]                    wReadData,
    output logic                           oIRQ
);

    localparam int unsigned     HW          = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0]   HoldoffInit = HW'(HOLDOFF);

    logic [3:0][31:0]   frame_q, frame_d;
    logic [3:0][31:0]   last_q, last_d;
    logic [3:0][HW-1:0] holdoff_q, holdoff_d;
    logic [3:0]         valid_q, valid_d;
    logic [3:0]         overrun_q, overrun_d;
    logic [7:0]         drop_q, drop_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         rr_q, rr_d;
    logic [2:0]         last_served_q, last_served_d;
    logic               next_empty_q, next_empty_d;

    logic               rd_ctrl, rd_data, rd_stat, rd_next, wr_ctrl, clr;
    logic               frame_hit, next_found;
    logic [1:0]         tgt, next_idx, probe_idx;
    logic [3:0]         valid_cl;
    logic [31:0]        rdata;

    logic unused_bus;
    assign unused_bus = ^{bus.wWriteData[31:9], bus.wWriteData[7:2], bus.wByteEnable[3:2]};

    assign rd_ctrl = bus.wReadEnable && (bus.wAddress == BASE_ADDR);
    assign rd_data = bus.wReadEnable && (bus.wAddress == BASE_ADDR + 32'd4);
    assign rd_stat = bus.wReadEnable && (bus.wAddress == BASE_ADDR + 32'd8);
    assign rd_next = bus.wReadEnable && (bus.wAddress == BASE_ADDR + 32'd12);
    assign wr_ctrl = bus.wWriteEnable && (bus.wAddress == BASE_ADDR);
    assign clr     = wr_ctrl && bus.wByteEnable[1] && bus.wWriteData[8];

    // Lowest matching customer code wins.
    always_comb begin
        frame_hit = 1'b1;
        tgt       = 2'd0;
        if (iFrame[15:0] == ID0)      tgt = 2'd0;
        else if (iFrame[15:0] == ID1) tgt = 2'd1;
        else if (iFrame[15:0] == ID2) tgt = 2'd2;
        else if (iFrame[15:0] == ID3) tgt = 2'd3;
        else                          frame_hit = 1'b0;
    end

    always_comb begin
        next_found = 1'b0;
        next_idx   = rr_q;
        probe_idx  = rr_q;
        for (int k = 0; k < 4; k++) begin
            probe_idx = rr_q + 2'(k);
            if (!next_found && valid_q[probe_idx]) begin
                next_found = 1'b1;
                next_idx   = probe_idx;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        unique case (1'b1)
            rd_ctrl: rdata = {30'b0, sel_q};
            rd_data: rdata = frame_q[sel_q];
            rd_stat: rdata = {4'b0, next_empty_q, last_served_q, drop_q,
                              4'b0, overrun_q, 4'b0, valid_q};
            rd_next: rdata = next_found ? frame_q[next_idx] : 32'h0;
            default: rdata = 32'h0;
        endcase
    end

    assign wReadData = (rd_ctrl || rd_data || rd_stat || rd_next) ? rdata : 32'hzzzzzzzz;
    assign oIRQ      = |valid_q;

    always_comb begin
        frame_d       = frame_q;
        last_d        = last_q;
        holdoff_d     = holdoff_q;
        sel_d         = sel_q;
        rr_d          = rr_q;
        last_served_d = last_served_q;
        next_empty_d  = next_empty_q;
        valid_d       = clr ? 4'b0 : valid_q;
        overrun_d     = clr ? 4'b0 : overrun_q;
        drop_d        = clr ? 8'h0 : drop_q;
        valid_cl      = valid_d;

        for (int i = 0; i < 4; i++) begin
            if (holdoff_q[i] != '0) holdoff_d[i] = holdoff_q[i] - HW'(1);
        end

        if (wr_ctrl && bus.wByteEnable[0]) sel_d = bus.wWriteData[1:0];

        if (rd_data) valid_d[sel_q] = 1'b0;

        if (rd_next) begin
            if (next_found) begin
                valid_d[next_idx] = 1'b0;
                last_served_d     = {1'b0, next_idx};
                rr_d              = next_idx + 2'd1;
                next_empty_d      = 1'b0;
            end else begin
                next_empty_d = 1'b1;
            end
        end

        // Arrival after read-clear so a new frame keeps the slot valid.
        if (iFrameValid) begin
            if (frame_hit) begin
                if (!((iFrame == last_q[tgt]) && (holdoff_q[tgt] != '0))) begin
                    frame_d[tgt]   = iFrame;
                    last_d[tgt]    = iFrame;
                    holdoff_d[tgt] = HoldoffInit;
                    overrun_d[tgt] = overrun_d[tgt] | valid_cl[tgt];
                    valid_d[tgt]   = 1'b1;
                end
            end else if (drop_d != 8'hFF) begin
                drop_d = drop_d + 8'd1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (Reset) begin
            frame_q       <= '0;
            last_q        <= '0;
            holdoff_q     <= '0;
            valid_q       <= '0;
            overrun_q     <= '0;
            drop_q        <= '0;
            sel_q         <= '0;
            rr_q          <= '0;
            last_served_q <= '0;
            next_empty_q  <= 1'b1;
        end else begin
            frame_q       <= frame_d;
            last_q        <= last_d;
            holdoff_q     <= holdoff_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            drop_q        <= drop_d;
            sel_q         <= sel_d;
            rr_q          <= rr_d;
            last_served_q <= last_served_d;
            next_empty_q  <= next_empty_d;
        end
    end

endmodule
